hps_led_pwm: RTL

//  Avalon-MM slave output port for board LEDs: successor of the 8-bit HPS LED PIO.

---
 rtl/hps_led_pkg.sv | 18 +
 rtl/hps_led_pwm_if.sv | 13 +
 rtl/hps_led_blink_timer.sv | 32 +++
 rtl/hps_led_pwm.sv | 88 ++++++++
 4 files changed

// File: rtl/hps_led_pkg.sv
// Shared definitions for the HPS LED PWM port: register word addresses and
// the DUTY reset-value helper.
package hps_led_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MODE   = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam logic [2:0] ADDR_OUT    = 3'd6;

  // All-ones value of a PWM_BITS-wide duty field (widths up to 16 bits).
  function automatic logic [15:0] duty_all_ones(input int unsigned bits);
    return 16'((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/hps_led_pwm_if.sv
// Avalon-MM slave bus bundle for the LED port (zero wait states, read latency 0).
interface hps_led_pwm_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/hps_led_blink_timer.sv
// Blink half-period timer: counts clk cycles up to period-1 and toggles phase.
// A period write restarts the count and forces phase high.
module hps_led_blink_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] period,
  input  logic        period_wr,
  output logic        phase
);

  logic [31:0] blink_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (period_wr) begin
      // Clearing here keeps a shrinking period from running the count past it.
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (period != 32'd0) begin
      if (blink_cnt == period - 32'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/hps_led_pwm.sv
// LED output port with atomic set/clear, per-bit blink and global PWM brightness.
// Holds the register file, PWM counter, read mux and registered LED drive.
module hps_led_pwm
  import hps_led_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  hps_led_pwm_if.slave     bus,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PWM_BITS-1:0] DUTY_RST = PWM_BITS'(duty_all_ones(PWM_BITS));

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mode;
  logic [31:0]         period;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic                phase;
  logic                wr_en;
  logic                period_wr;
  logic [WIDTH-1:0]    wd;
  logic [WIDTH-1:0]    led_next;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign period_wr = wr_en && (bus.address == ADDR_PERIOD);
  assign wd        = bus.writedata[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= '0;
      mode   <= '0;
      period <= '0;
      duty   <= DUTY_RST;
    end else if (wr_en) begin
      unique case (bus.address)
        ADDR_DATA:   data   <= wd;
        ADDR_SET:    data   <= data | wd;
        ADDR_CLEAR:  data   <= data & ~wd;
        ADDR_MODE:   mode   <= wd;
        ADDR_PERIOD: period <= bus.writedata;
        ADDR_DUTY:   duty   <= bus.writedata[PWM_BITS-1:0];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Full-scale duty must stay lit on the one count where pwm_cnt < duty fails.
  assign pwm_on = (duty == DUTY_RST) || (pwm_cnt < duty);

  hps_led_blink_timer u_blink (
    .clk       (clk),
    .reset_n   (reset_n),
    .period    (period),
    .period_wr (period_wr),
    .phase     (phase)
  );

  assign led_next = data & {WIDTH{pwm_on}} & (~mode | {WIDTH{phase}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= '0;
    else          out_port <= led_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_DATA:   bus.readdata = 32'(data);
      ADDR_MODE:   bus.readdata = 32'(mode);
      ADDR_PERIOD: bus.readdata = period;
      ADDR_DUTY:   bus.readdata = 32'(duty);
      ADDR_OUT:    bus.readdata = 32'(out_port);
      default:     bus.readdata = '0;
    endcase
  end

endmodule
